// File: rtl/maxpool_pkg.sv
// Shared constants for the 2x2 stride-2 int8 max-pool stage.
// Combinational helpers only; no latency.
// No flow control; constants and functions only.
package maxpool_pkg;

   localparam int INT8_W = 8;
   localparam int CNT_W  = 9;

   localparam logic [2:0] SEL_L1 = 3'd0;
   localparam logic [2:0] SEL_L2 = 3'd1;
   localparam logic [2:0] SEL_L3 = 3'd2;
   localparam logic [2:0] SEL_L4 = 3'd3;
   localparam logic [2:0] SEL_L5 = 3'd4;
   localparam logic [2:0] SEL_L6 = 3'd5;

   // Byte lane positions inside the 32-bit window batch
   localparam int LANE_TL = 0;
   localparam int LANE_TR = 1;
   localparam int LANE_BL = 2;
   localparam int LANE_BR = 3;

   // Codes 6 and 7 fall through to the longest line
   function automatic logic [CNT_W-1:0] line_len_of(input logic [2:0] s,
                                                    input int w1, input int w2,
                                                    input int w3, input int w4,
                                                    input int w5, input int w6);
      logic [CNT_W-1:0] len;
      case (s)
         SEL_L1:  len = CNT_W'(w1);
         SEL_L2:  len = CNT_W'(w2);
         SEL_L3:  len = CNT_W'(w3);
         SEL_L4:  len = CNT_W'(w4);
         SEL_L5:  len = CNT_W'(w5);
         default: len = CNT_W'(w6);
      endcase
      return len;
   endfunction

endpackage

// File: rtl/maxpool_2x2_stream_max.sv
// Registered signed 2-input int8 max with load enable.
// Latency: 1 cycle.
// No backpressure; output holds while en is low.
module com_max_int8
   import maxpool_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [INT8_W-1:0] a,
   input  logic signed [INT8_W-1:0] b,
   output logic signed [INT8_W-1:0] y
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  y <= '0;
      else if (en) y <= (a > b) ? a : b;
   end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 int8 max-pool over the line-buffer window stream (optional MAXPOOL_STRIDE1_EN).
// Latency: 2 cycles from accepted beat to pool_valid.
// No backpressure: every pool_valid beat must be taken downstream.
module maxpool_2x2_stream
   import maxpool_pkg::*;
#(
   parameter int LINE_W1 = 16,
   parameter int LINE_W2 = 30,
   parameter int LINE_W3 = 58,
   parameter int LINE_W4 = 114,
   parameter int LINE_W5 = 226,
   parameter int LINE_W6 = 450,
   parameter int CNT_W   = 9
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [2:0]               sel,
   input  logic                     frame_start,
   input  logic                     in_valid,
`ifdef MAXPOOL_STRIDE1_EN
   input  logic                     stride1,
`endif
   input  logic [31:0]              ifm_win2x2_batch,
   output logic signed [INT8_W-1:0] pool_out,
   output logic                     pool_valid,
   output logic                     line_done
);

   logic [2:0]       sel_q, sel_eff;
   logic [CNT_W-1:0] col, col_eff, line_len;
   logic             row_par, row_eff;
   logic             wrap, last_s2, emit_s2, emit, last;
   logic             e1, l1;
   logic signed [INT8_W-1:0] m_top, m_bot;

   // frame_start beat is positioned at col 0 of row 0 under the new sel
   assign sel_eff  = frame_start ? sel  : sel_q;
   assign col_eff  = frame_start ? '0   : col;
   assign row_eff  = frame_start ? 1'b0 : row_par;
   assign line_len = CNT_W'(line_len_of(sel_eff, LINE_W1, LINE_W2, LINE_W3,
                                        LINE_W4, LINE_W5, LINE_W6));

   assign wrap    = (col_eff == line_len - 1'b1);
   assign last_s2 = wrap | (line_len[0] & (col_eff == line_len - 2'd2));
   assign emit_s2 = in_valid & col_eff[0] & row_eff;

`ifdef MAXPOOL_STRIDE1_EN
   logic stride1_q, row_seen, s1_eff, seen_eff;

   assign s1_eff   = frame_start ? stride1 : stride1_q;
   assign seen_eff = frame_start ? 1'b0    : row_seen;
   assign emit     = s1_eff ? (in_valid & (col_eff != '0) & seen_eff) : emit_s2;
   assign last     = s1_eff ? wrap : last_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stride1_q <= 1'b0;
         row_seen  <= 1'b0;
      end else begin
         if (frame_start) stride1_q <= stride1;
         row_seen <= seen_eff | (in_valid & wrap);
      end
   end
`else
   assign emit = emit_s2;
   assign last = last_s2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         col     <= '0;
         row_par <= 1'b0;
      end else begin
         if (frame_start) sel_q <= sel;
         if (in_valid) begin
            col     <= wrap ? '0 : col_eff + 1'b1;
            row_par <= wrap ? ~row_eff : row_eff;
         end else begin
            col     <= col_eff;
            row_par <= row_eff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1         <= 1'b0;
         l1         <= 1'b0;
         pool_valid <= 1'b0;
         line_done  <= 1'b0;
      end else begin
         e1         <= emit;
         l1         <= emit & last;
         pool_valid <= e1;
         line_done  <= e1 & l1;
      end
   end

   com_max_int8 u_max_top (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .a     (ifm_win2x2_batch[LANE_TL*INT8_W +: INT8_W]),
      .b     (ifm_win2x2_batch[LANE_TR*INT8_W +: INT8_W]),
      .y     (m_top)
   );

   com_max_int8 u_max_bot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .a     (ifm_win2x2_batch[LANE_BL*INT8_W +: INT8_W]),
      .b     (ifm_win2x2_batch[LANE_BR*INT8_W +: INT8_W]),
      .y     (m_bot)
   );

   // Output only reloads on emitting beats so it holds across non-emits
   com_max_int8 u_max_out (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (e1),
      .a     (m_top),
      .b     (m_bot),
      .y     (pool_out)
   );

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Randomized self-checking bench for maxpool_2x2_stream against a frame-position model.
module tb_maxpool_2x2_stream;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [2:0]         sel;
   logic               frame_start;
   logic               in_valid;
   logic               stride1;
   logic [31:0]        ifm_win2x2_batch;
   logic signed [7:0]  pool_out;
   logic               pool_valid;
   logic               line_done;

   always #5 clk = ~clk;

   maxpool_2x2_stream dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sel              (sel),
      .frame_start      (frame_start),
      .in_valid         (in_valid),
`ifdef MAXPOOL_STRIDE1_EN
      .stride1          (stride1),
`endif
      .ifm_win2x2_batch (ifm_win2x2_batch),
      .pool_out         (pool_out),
      .pool_valid       (pool_valid),
      .line_done        (line_done)
   );

   typedef struct {
      int         due;
      logic [7:0] val;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         cyc    = 0;
   int         n_emit = 0;
   int         n_done = 0;
   logic [7:0] last_out = '0;

   // frame-position model: beat index since frame start
   int m_k   = 0;
   int m_len = 16;
   bit m_s1  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
   endtask

   function automatic int len_of(input int s);
      case (s)
         0: return 16;
         1: return 30;
         2: return 58;
         3: return 114;
         4: return 226;
         default: return 450;
      endcase
   endfunction

   function automatic logic [7:0] win_max(input logic [31:0] w);
      int best = -128;
      for (int i = 0; i < 4; i++) begin
         logic signed [7:0] b;
         int v;
         b = w[i*8 +: 8];
         v = b;
         if (v > best) best = v;
      end
      return best[7:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", {31'b0, pool_valid}, 32'd0);
         chk("rst_out", {24'b0, $unsigned(pool_out)}, 32'd0);
         chk("rst_done", {31'b0, line_done}, 32'd0);
         exp_q.delete();
      end else begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("missed_emit", 32'(exp_q[0].due), 32'(cyc));
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("pool_valid", {31'b0, pool_valid}, 32'd1);
            chk("pool_out", {24'b0, $unsigned(pool_out)}, {24'b0, exp_q[0].val});
            chk("line_done", {31'b0, line_done}, {31'b0, exp_q[0].last});
            void'(exp_q.pop_front());
         end else begin
            chk("idle_valid", {31'b0, pool_valid}, 32'd0);
            chk("idle_done", {31'b0, line_done}, 32'd0);
         end
         if (pool_valid) begin
            n_emit++;
            last_out = pool_out;
         end
         if (line_done) n_done++;
      end
   end

   task automatic drive(input bit fs, input bit v, input int s, input logic [31:0] d, input bit s1);
      int col, row;
      bit emit, last;
      frame_start      = fs;
      in_valid         = v;
      sel              = 3'(s);
      stride1          = s1;
      ifm_win2x2_batch = d;
      if (fs) begin
         m_k   = 0;
         m_len = len_of(s);
`ifdef MAXPOOL_STRIDE1_EN
         m_s1  = s1;
`else
         m_s1  = 1'b0;
`endif
      end
      if (v) begin
         col = m_k % m_len;
         row = m_k / m_len;
         if (m_s1) begin
            emit = (col >= 1) && (row >= 1);
            last = (col == m_len - 1);
         end else begin
            emit = (col % 2 == 1) && (row % 2 == 1);
            last = (col == m_len - 1) || ((m_len % 2 == 1) && (col == m_len - 2));
         end
         if (emit) exp_q.push_back('{due: cyc + 2, val: win_max(d), last: last});
         m_k++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, $urandom, 1'b0);
   endtask

   task automatic sel0_frame(input bit bubbles);
      int k = 0;
      int c = 0;
      while (k < 64) begin
         if (bubbles && (c % 3 == 2)) begin
            drive(1'b0, 1'b0, 0, $urandom, 1'b0);
         end else begin
            drive(k == 0, 1'b1, 0, {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)}, 1'b0);
            k++;
         end
         c++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      frame_start = 1'b0;
      in_valid = 1'b1;
      sel = '0;
      stride1 = 1'b0;
      ifm_win2x2_batch = $urandom;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         ifm_win2x2_batch = $urandom;
      end
      rst_n = 1'b1;
      m_k = 0; m_len = 16; m_s1 = 1'b0;

      // after reset, no frame_start: fewer than a row plus one beat gives no output
      n_emit = 0;
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, $urandom_range(0, 7), $urandom, 1'b0);
      idle(3);
      chk("no_emit_pre_fs", 32'(n_emit), 32'd0);

      n_emit = 0; n_done = 0;
      sel0_frame(1'b0);
      idle(3);
      chk("sel0_emits", 32'(n_emit), 32'd16);
      chk("sel0_done", 32'(n_done), 32'd2);
      chk("sel0_final", {24'b0, last_out}, 32'd66);

      n_emit = 0; n_done = 0;
      sel0_frame(1'b1);
      idle(3);
      chk("bubble_emits", 32'(n_emit), 32'd16);
      chk("bubble_done", 32'(n_done), 32'd2);

      for (int t = 0; t < 2; t++) begin
         drive(1'b1, 1'b1, 0, $urandom, 1'b0);
         for (int i = 1; i < 17; i++) drive(1'b0, 1'b1, 0, $urandom, 1'b0);
         drive(1'b0, 1'b1, 0, (t == 0) ? 32'h00FF7F80 : 32'hFFFE8180, 1'b0);
         idle(3);
         chk(t == 0 ? "signed_a" : "signed_b", {24'b0, last_out}, (t == 0) ? 32'h7F : 32'hFF);
      end

      // frame_start at col 7 of row 1, switching to the 114-pixel line
      n_emit = 0;
      drive(1'b1, 1'b1, 0, $urandom, 1'b0);
      for (int i = 1; i < 23; i++) drive(1'b0, 1'b1, 0, $urandom, 1'b0);
      drive(1'b1, 1'b1, 3, $urandom, 1'b0);
      for (int i = 1; i < 116; i++) drive(1'b0, 1'b1, 3, $urandom, 1'b0);
      idle(3);
      chk("midrow_emits", 32'(n_emit), 32'd4);

      for (int f = 0; f < 6; f++) begin
         int s, beats, k;
         s = $urandom_range(0, 7);
         beats = len_of(s) * $urandom_range(2, 4);
         k = 0;
         while (k < beats) begin
            if (k > 0 && $urandom_range(0, 3) == 0) begin
               drive(1'b0, 1'b0, s, $urandom, 1'b0);
            end else begin
               drive(k == 0, 1'b1, s, $urandom, 1'b0);
               k++;
            end
         end
      end
      idle(3);

`ifdef MAXPOOL_STRIDE1_EN
      n_emit = 0; n_done = 0;
      drive(1'b1, 1'b1, 0, $urandom, 1'b1);
      for (int i = 1; i < 48; i++) drive(1'b0, 1'b1, 0, $urandom, 1'b0);
      idle(3);
      chk("s1_emits", 32'(n_emit), 32'd30);
      chk("s1_done", 32'(n_done), 32'd2);
`endif

      idle(2);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
